// File: rtl/sfp_link_controller.sv
// Bring-up and supervision sequencer for one 10G SFP+ lane: laser off, GT reset,
// wait for GT lock, PCS reset, wait for stable block lock, then supervise link-up.
module sfp_link_controller #(
    parameter int TX_DISABLE_CYCLES   = 156250,
    parameter int GT_RESET_CYCLES     = 16,
    parameter int PCS_RESET_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 1562500,
    parameter int STABLE_CYCLES       = 15625,
    parameter int MAX_RETRIES         = 7
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic       i_qpll_lock,
    input  logic       i_tx_reset_done,
    input  logic       i_rx_reset_done,
    input  logic       i_block_lock,
    output logic       o_tx_disable,
    output logic       o_gt_reset,
    output logic       o_pcs_reset,
    output logic       o_link_up,
    output logic       o_fault,
    output logic [2:0] o_state,
    output logic [2:0] o_retry_count
);

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_CYCLES = max_of(max_of(max_of(TX_DISABLE_CYCLES, GT_RESET_CYCLES),
                                              max_of(PCS_RESET_CYCLES, LOCK_TIMEOUT_CYCLES)),
                                       STABLE_CYCLES);
    localparam int CW = $clog2(MAX_CYCLES) + 1;

    localparam logic [CW-1:0] TX_OFF_LAST    = CW'(TX_DISABLE_CYCLES - 1);
    localparam logic [CW-1:0] GT_RESET_LAST  = CW'(GT_RESET_CYCLES - 1);
    localparam logic [CW-1:0] PCS_RESET_LAST = CW'(PCS_RESET_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST   = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST    = CW'(STABLE_CYCLES - 1);
    localparam logic [2:0]    RETRY_MAX      = 3'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_DISABLED  = 3'd0,
        ST_TX_OFF    = 3'd1,
        ST_GT_RESET  = 3'd2,
        ST_WAIT_GT   = 3'd3,
        ST_PCS_RESET = 3'd4,
        ST_WAIT_LOCK = 3'd5,
        ST_LINK_UP   = 3'd6,
        ST_FAULT     = 3'd7
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] stable_cnt;
    logic [2:0]    next_retry;
    logic          retry_go;
    logic          gt_ready;
    logic          counting;

    assign o_state  = state;
    assign gt_ready = i_qpll_lock & i_tx_reset_done & i_rx_reset_done;
    assign counting = state inside {ST_TX_OFF, ST_GT_RESET, ST_WAIT_GT,
                                    ST_PCS_RESET, ST_WAIT_LOCK};

    // Success conditions are tested before the timeout so they win a tie.
    always_comb begin
        next_state = state;
        next_retry = o_retry_count;
        retry_go   = 1'b0;
        if (!i_enable) begin
            next_state = ST_DISABLED;
            next_retry = '0;
        end else begin
            case (state)
                ST_DISABLED:  next_state = ST_TX_OFF;
                ST_TX_OFF: begin
                    if (cnt == TX_OFF_LAST) next_state = ST_GT_RESET;
                end
                ST_GT_RESET: begin
                    if (cnt == GT_RESET_LAST) next_state = ST_WAIT_GT;
                end
                ST_WAIT_GT: begin
                    if (gt_ready) next_state = ST_PCS_RESET;
                    else if (cnt == TIMEOUT_LAST) retry_go = 1'b1;
                end
                ST_PCS_RESET: begin
                    if (cnt == PCS_RESET_LAST) next_state = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (i_block_lock && stable_cnt == STABLE_LAST) begin
                        next_state = ST_LINK_UP;
                        next_retry = '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        retry_go = 1'b1;
                    end
                end
                ST_LINK_UP: begin
                    if (!i_block_lock || !i_qpll_lock) retry_go = 1'b1;
                end
                ST_FAULT:     next_state = ST_FAULT;
                default:      next_state = ST_DISABLED;
            endcase

            if (retry_go) begin
                if (o_retry_count >= RETRY_MAX) begin
                    next_state = ST_FAULT;
                end else begin
                    next_state = ST_TX_OFF;
                    next_retry = o_retry_count + 3'd1;
                end
            end
        end
    end

    // Outputs decode next_state so they change on the same edge as o_state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= ST_DISABLED;
            cnt           <= '0;
            stable_cnt    <= '0;
            o_retry_count <= '0;
            o_tx_disable  <= 1'b1;
            o_gt_reset    <= 1'b1;
            o_pcs_reset   <= 1'b1;
            o_link_up     <= 1'b0;
            o_fault       <= 1'b0;
        end else begin
            state         <= next_state;
            o_retry_count <= next_retry;

            if (next_state != state) cnt <= '0;
            else if (counting)       cnt <= cnt + CW'(1);

            if (state == ST_WAIT_LOCK && next_state == ST_WAIT_LOCK && i_block_lock)
                stable_cnt <= stable_cnt + CW'(1);
            else
                stable_cnt <= '0;

            o_tx_disable <= next_state inside {ST_DISABLED, ST_TX_OFF, ST_GT_RESET,
                                               ST_WAIT_GT, ST_FAULT};
            o_gt_reset   <= next_state inside {ST_DISABLED, ST_TX_OFF, ST_GT_RESET, ST_FAULT};
            o_pcs_reset  <= !(next_state inside {ST_WAIT_LOCK, ST_LINK_UP});
            o_link_up    <= (next_state == ST_LINK_UP);
            o_fault      <= (next_state == ST_FAULT);
        end
    end

endmodule

// File: tb/tb_sfp_link_controller.sv
// Directed bench for sfp_link_controller with shortened timing parameters
// (TX_OFF 8, GT_RESET 4, PCS_RESET 4, timeout 32, stable 8, 2 retries).
module tb_sfp_link_controller;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       qpll_lock;
    logic       tx_reset_done;
    logic       rx_reset_done;
    logic       block_lock;
    logic       tx_disable;
    logic       gt_reset;
    logic       pcs_reset;
    logic       link_up;
    logic       fault;
    logic [2:0] state;
    logic [2:0] retry_count;

    int total = 0;
    int bad   = 0;
    logic [2:0] exp_q[$];

    sfp_link_controller #(
        .TX_DISABLE_CYCLES  (8),
        .GT_RESET_CYCLES    (4),
        .PCS_RESET_CYCLES   (4),
        .LOCK_TIMEOUT_CYCLES(32),
        .STABLE_CYCLES      (8),
        .MAX_RETRIES        (2)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_enable       (enable),
        .i_qpll_lock    (qpll_lock),
        .i_tx_reset_done(tx_reset_done),
        .i_rx_reset_done(rx_reset_done),
        .i_block_lock   (block_lock),
        .o_tx_disable   (tx_disable),
        .o_gt_reset     (gt_reset),
        .o_pcs_reset    (pcs_reset),
        .o_link_up      (link_up),
        .o_fault        (fault),
        .o_state        (state),
        .o_retry_count  (retry_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Expected output decode for a given state.
    task automatic check_outputs(input string tag, input logic [2:0] s);
        check({tag, "_state"}, 32'(state), 32'(s));
        check({tag, "_txdis"}, 32'(tx_disable), 32'((s <= 3'd3) || (s == 3'd7)));
        check({tag, "_gtrst"}, 32'(gt_reset), 32'((s <= 3'd2) || (s == 3'd7)));
        check({tag, "_pcsrst"}, 32'(pcs_reset), 32'(!((s == 3'd5) || (s == 3'd6))));
        check({tag, "_linkup"}, 32'(link_up), 32'(s == 3'd6));
        check({tag, "_fault"}, 32'(fault), 32'(s == 3'd7));
    endtask

    task automatic wait_state(input logic [2:0] s, input int limit, input string tag,
                              output int n);
        n = 0;
        while (state !== s && n < limit) begin
            step();
            n++;
        end
        check({tag, "_reach"}, 32'(state == s), 32'd1);
    endtask

    initial begin
        int n;
        int m;
        logic [2:0] e;

        reset         = 1'b1;
        enable        = 1'b0;
        qpll_lock     = 1'b1;
        tx_reset_done = 1'b1;
        rx_reset_done = 1'b1;
        block_lock    = 1'b1;
        step();
        step();
        check_outputs("rst", 3'd0);
        check("rst_retry", 32'(retry_count), 32'd0);
        reset = 1'b0;
        step();
        check("idle_state", 32'(state), 32'd0);

        // Clean bring-up: residency 8,4,1,4,8 then LINK_UP, 26 cycles after enable.
        for (int i = 0; i < 8; i++) exp_q.push_back(3'd1);
        for (int i = 0; i < 4; i++) exp_q.push_back(3'd2);
        exp_q.push_back(3'd3);
        for (int i = 0; i < 4; i++) exp_q.push_back(3'd4);
        for (int i = 0; i < 8; i++) exp_q.push_back(3'd5);
        exp_q.push_back(3'd6);
        enable = 1'b1;
        while (exp_q.size() > 0) begin
            step();
            e = exp_q.pop_front();
            check_outputs("bringup", e);
        end
        check("bringup_retry", 32'(retry_count), 32'd0);
        step();
        check("bringup_hold", 32'(state), 32'd6);

        // Lock glitch on the 6th WAIT_LOCK cycle restarts the stable count.
        enable = 1'b0;
        step();
        check_outputs("dis", 3'd0);
        enable = 1'b1;
        wait_state(3'd5, 40, "glitch", n);
        repeat (5) step();
        block_lock = 1'b0;
        step();
        block_lock = 1'b1;
        check_outputs("glitch_c7", 3'd5);
        for (int i = 0; i < 7; i++) begin
            step();
            check("glitch_wait", 32'(state), 32'd5);
        end
        step();
        check_outputs("glitch_up", 3'd6);
        check("glitch_retry", 32'(retry_count), 32'd0);

        // Link loss in LINK_UP: one retry, then relink clears the count.
        block_lock = 1'b0;
        step();
        block_lock = 1'b1;
        check_outputs("loss", 3'd1);
        check("loss_retry", 32'(retry_count), 32'd1);
        wait_state(3'd6, 40, "relink", n);
        check("relink_cycles", 32'(n), 32'd25);
        check("relink_retry", 32'(retry_count), 32'd0);

        // Exhausted retries with QPLL never locking.
        enable = 1'b0;
        step();
        qpll_lock = 1'b0;
        enable    = 1'b1;
        for (int a = 0; a < 3; a++) begin
            wait_state(3'd3, 40, "ex_wait", n);
            m = 1;
            step();
            while (state == 3'd3 && m < 40) begin
                m++;
                step();
            end
            check("ex_timeout", 32'(m), 32'd32);
            if (a < 2) begin
                check("ex_state", 32'(state), 32'd1);
                check("ex_retry", 32'(retry_count), 32'(a + 1));
            end else begin
                check_outputs("ex_fault", 3'd7);
                check("ex_fault_retry", 32'(retry_count), 32'd2);
            end
        end
        repeat (3) step();
        check("fault_hold", 32'(state), 32'd7);
        enable = 1'b0;
        step();
        check_outputs("fault_clr", 3'd0);
        check("fault_clr_retry", 32'(retry_count), 32'd0);

        // Success on the timeout cycle of WAIT_GT wins.
        enable = 1'b1;
        wait_state(3'd3, 40, "race_ok", n);
        repeat (31) step();
        qpll_lock = 1'b1;
        step();
        check_outputs("race_ok", 3'd4);
        check("race_ok_retry", 32'(retry_count), 32'd0);

        // Enable drop on the timeout cycle wins over the retry.
        enable = 1'b0;
        step();
        qpll_lock = 1'b0;
        enable    = 1'b1;
        wait_state(3'd3, 40, "race_dis_a", n);
        repeat (32) step();
        check("race_dis_first", 32'(state), 32'd1);
        check("race_dis_first_retry", 32'(retry_count), 32'd1);
        wait_state(3'd3, 40, "race_dis_b", n);
        repeat (31) step();
        enable = 1'b0;
        step();
        check_outputs("race_dis", 3'd0);
        check("race_dis_retry", 32'(retry_count), 32'd0);

        // Reset pulse during GT_RESET.
        qpll_lock = 1'b1;
        enable    = 1'b1;
        wait_state(3'd2, 40, "midrst", n);
        step();
        reset = 1'b1;
        step();
        check_outputs("midrst", 3'd0);
        check("midrst_retry", 32'(retry_count), 32'd0);
        reset = 1'b0;
        step();
        check("midrst_restart", 32'(state), 32'd1);
        wait_state(3'd6, 40, "midrst_up", n);
        check("midrst_up_cycles", 32'(n), 32'd25);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sfp_link_controller.md
# sfp_link_controller

Bring-up and supervision sequencer for one 10G SFP+ lane (transceiver + 64b/66b PCS) inside the ethernet subsystem, clocked from the 156.25 MHz reference domain. It drives the SFP TX_DISABLE pin and the GT/PCS resets. It waits for QPLL lock, reset-done and PCS block lock, declares link-up, and retries bring-up on timeout or link loss. It latches a fault after a bounded number of failed attempts and exports state and status for the LED status block.

## Interface
Parameters:
- TX_DISABLE_CYCLES, 156250: laser-off hold before each attempt (1 ms).
- GT_RESET_CYCLES, 16: width of the GT reset pulse.
- PCS_RESET_CYCLES, 16: width of the PCS reset pulse.
- LOCK_TIMEOUT_CYCLES, 1562500: per-wait-state timeout (10 ms).
- STABLE_CYCLES, 15625: required continuous block lock before link-up (100 us).
- MAX_RETRIES, 7: failed attempts tolerated before FAULT.

Ports:
- i_clk  in  1  156.25 MHz; the only clock.
- i_reset  in  1  synchronous, active-high.
- i_enable  in  1  lane enable (DIP switch, already synchronised).
- i_qpll_lock  in  1  transceiver QPLL locked.
- i_tx_reset_done  in  1  GT TX reset complete.
- i_rx_reset_done  in  1  GT RX reset complete.
- i_block_lock  in  1  PCS 66b block lock.
- o_tx_disable  out  1  to SFP TX_DISABLE; 1 = laser off.
- o_gt_reset  out  1  GT reset, active-high.
- o_pcs_reset  out  1  PCS reset, active-high.
- o_link_up  out  1  link usable.
- o_fault  out  1  retries exhausted.
- o_state  out  3  current state encoding.
- o_retry_count  out  3  failed attempts in the current bring-up.

## Operation
- States and encodings: DISABLED=0, TX_OFF=1, GT_RESET=2, WAIT_GT=3, PCS_RESET=4, WAIT_LOCK=5, LINK_UP=6, FAULT=7.
- Output decode, registered and consistent with o_state in the same cycle:
  - o_tx_disable=1 in states 0–3 and 7.
  - o_gt_reset=1 in states 0–2 and 7.
  - o_pcs_reset=1 in every state except 5 and 6.
  - o_link_up=1 only in state 6.
  - o_fault=1 only in state 7.
- Reset values: state DISABLED, o_tx_disable=1, o_gt_reset=1, o_pcs_reset=1, o_link_up=0, o_fault=0, o_retry_count=0. All counters are cleared.
- One shared cycle counter is cleared on every state change. In WAIT_LOCK a separate stable counter runs alongside it.
- Transition priority: i_reset, then i_enable=0, then per-state rules.
  - i_enable=0 in any state → DISABLED next cycle; o_retry_count is cleared.
- Per-state rules:
  - DISABLED: i_enable=1 → TX_OFF.
  - TX_OFF: after TX_DISABLE_CYCLES → GT_RESET.
  - GT_RESET: after GT_RESET_CYCLES → WAIT_GT.
  - WAIT_GT: i_qpll_lock, i_tx_reset_done and i_rx_reset_done all 1 in the same cycle → PCS_RESET. Otherwise, counter reaching LOCK_TIMEOUT_CYCLES-1 → RETRY.
  - PCS_RESET: after PCS_RESET_CYCLES → WAIT_LOCK.
  - WAIT_LOCK: the stable counter increments while i_block_lock=1 and clears on any 0. Stable counter reaching STABLE_CYCLES-1 with lock=1 → LINK_UP. Otherwise, timeout as in WAIT_GT → RETRY.
  - LINK_UP: on entry, o_retry_count clears to 0. i_block_lock=0 or i_qpll_lock=0 for any single cycle → RETRY.
  - FAULT: held until i_enable=0.
- RETRY is a transition rule, not a state:
  - If o_retry_count==MAX_RETRIES → FAULT.
  - Otherwise o_retry_count+1 → TX_OFF.
- Counter width: $clog2 of the largest cycle parameter, +1. o_retry_count saturates at MAX_RETRIES; MAX_RETRIES must be ≤7.

## Timing
- A condition sampled at edge N changes o_state and all outputs at edge N+1. No combinational input→output paths.
- Timed states (TX_OFF, GT_RESET, PCS_RESET) are occupied for exactly PARAM cycles. Transition occurs when counter==PARAM-1.
- Success beats timeout: when the success condition and the timeout occur in the same cycle, the success transition is taken.
- Link-up latency after entering WAIT_LOCK with lock already high: STABLE_CYCLES cycles.
- Link-loss reaction: o_link_up falls and o_tx_disable rises 1 cycle after i_block_lock falls.
- i_reset mid-sequence: outputs reach reset values at the next edge, regardless of state.

## Test plan
Bench parameters: TX_DISABLE=8, GT_RESET=4, PCS_RESET=4, LOCK_TIMEOUT=32, STABLE=8, MAX_RETRIES=2.
- Clean bring-up:
  - Stimulus: i_enable=1 with all status inputs high.
  - Required: states 1→2→3→4→5→6, residing 8, 4, 1, 4 and 8 cycles in states 1–5. o_link_up=1 exactly 26 cycles after enable is sampled. o_tx_disable falls on entry to PCS_RESET.
- Lock glitch in WAIT_LOCK:
  - Stimulus: drop i_block_lock for 1 cycle on the 6th WAIT_LOCK cycle.
  - Required: the stable counter restarts; link-up is delayed accordingly; no retry.
- Exhausted retries:
  - Stimulus: i_qpll_lock held 0.
  - Required: WAIT_GT times out after 32 cycles each attempt. o_retry_count goes 1, then 2; the third timeout enters FAULT with o_fault=1 and o_tx_disable=1. Deasserting i_enable returns to DISABLED with o_retry_count=0.
- Link loss in LINK_UP:
  - Stimulus: i_block_lock=0 for one cycle.
  - Required: next cycle o_state=1, o_link_up=0, o_retry_count=1. With lock restored, the lane re-reaches LINK_UP and o_retry_count returns to 0.
- Simultaneous events:
  - Stimulus: success condition on the timeout cycle in WAIT_GT.
  - Required: PCS_RESET is entered.
  - Stimulus: i_enable=0 on the same cycle as a timeout.
  - Required: DISABLED is entered.
- Mid-sequence reset:
  - Stimulus: i_reset pulsed during GT_RESET.
  - Required: the next cycle shows all reset values; bring-up restarts from DISABLED.
